// File: rtl/clause_arb_if.sv
// Handshake bundle between the clause sources, the switch tap and clause_arb.
// The slave modport is the arbiter's view; the master modport drives it.
interface clause_arb_if #(
  parameter int N_REQ = 4,
  parameter int CLA_W = 16,
  localparam int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][CLA_W-1:0] req_cla;
  logic [N_REQ-1:0]            req_ready;
  logic                        eng2sw_valid;
  logic                        clq_full;
  logic                        flush;
  logic [CLA_W-1:0]            carb2sw;
  logic                        carb2sw_valid;
  logic [IDX_W-1:0]            carb2sw_src;
  logic                        yield;

  modport slave (
    input  req_valid, req_cla, eng2sw_valid, clq_full, flush,
    output req_ready, carb2sw, carb2sw_valid, carb2sw_src, yield
  );

  modport master (
    output req_valid, req_cla, eng2sw_valid, clq_full, flush,
    input  req_ready, carb2sw, carb2sw_valid, carb2sw_src, yield
  );
endinterface

// File: rtl/clause_arb.sv
// Round-robin clause arbiter with a single output slot feeding the switch.
// Throttles on a full clause queue and periodically yields to the engine.
module clause_arb #(
  parameter int N_REQ      = 4,
  parameter int STARVE_MAX = 3,
  parameter int CLA_W      = 16,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input logic         clk,
  input logic         rst,
  clause_arb_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef logic [CLA_W-1:0] cla_t;

  cla_t             out_r;
  logic [IDX_W-1:0] src_r;
  logic [IDX_W-1:0] ptr_r;
  logic             vld_r;
  logic [CNT_W-1:0] starve_cnt_r;

  logic             yield_s;
  logic             fire_s;
  logic             load_en_s;
  logic             found_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic [N_REQ-1:0] req_ready_s;

  // Yield only while the engine is actually waiting on the switch.
  assign yield_s   = vld_r && bus.eng2sw_valid && (starve_cnt_r == CNT_W'(STARVE_MAX));
  assign fire_s    = vld_r && !bus.clq_full && !yield_s;
  assign load_en_s = (!vld_r || fire_s) && !bus.flush;

  // Round-robin scan starting at ptr_r, wrapping past the last requester.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(ptr_r) + k) % N_REQ;
      if (!found_s && bus.req_valid[j]) begin
        found_s   = 1'b1;
        gnt_idx_s = IDX_W'(j);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant and the pointer that follows the winner.
  always_comb begin
    req_ready_s = '0;
    ptr_nxt_s   = '0;
    if (load_en_s && found_s) begin
      req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;
    end else begin
      req_ready_s = '0;
    end
    if (gnt_idx_s == IDX_W'(N_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + IDX_W'(1);
    end
  end

  // Output slot: flush drops the held clause but keeps the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= 1'b0;
      ptr_r <= '0;
      out_r <= '0;
      src_r <= '0;
    end else if (bus.flush) begin
      vld_r <= 1'b0;
    end else if (load_en_s && found_s) begin
      out_r <= bus.req_cla[gnt_idx_s];
      src_r <= gnt_idx_s;
      vld_r <= 1'b1;
      ptr_r <= ptr_nxt_s;
    end else if (fire_s) begin
      vld_r <= 1'b0;
    end
  end

  // Engine starvation counter; clq_full stalls hold the count.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      starve_cnt_r <= '0;
    end else if (fire_s && bus.eng2sw_valid) begin
      if (starve_cnt_r != CNT_W'(STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end
    end else if (yield_s || !bus.eng2sw_valid) begin
      starve_cnt_r <= '0;
    end
  end

  assign bus.req_ready     = req_ready_s;
  assign bus.carb2sw       = out_r;
  assign bus.carb2sw_src   = src_r;
  assign bus.carb2sw_valid = fire_s;
  assign bus.yield         = yield_s;
endmodule

// File: tb/tb_clause_arb.sv
// Self-checking bench for clause_arb: directed phases push expected fires
// into a scoreboard that a negedge monitor pops and compares.
module tb_clause_arb;
  localparam int N_REQ = 4;
  localparam int CLA_W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] sb_q[$];

  clause_arb_if #(.N_REQ(N_REQ), .CLA_W(CLA_W)) bus ();

  clause_arb #(.N_REQ(N_REQ), .STARVE_MAX(3), .CLA_W(CLA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cla(input int base);
    for (int i = 0; i < N_REQ; i++) bus.req_cla[i] = 16'(base + i);
  endtask

  task automatic push_exp(input int src, input int cla);
    sb_q.push_back({16'(src), 16'(cla)});
  endtask

  // Scoreboard monitor: every fired clause must match the next expected one.
  always @(negedge clk) begin
    if (!rst && bus.carb2sw_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_fire", {16'(bus.carb2sw_src), bus.carb2sw}, 32'hFFFF_FFFF);
      end else begin
        check("fire", {16'(bus.carb2sw_src), bus.carb2sw}, sb_q.pop_front());
      end
    end
  end

  logic [3:0] p4_rr  [9] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000,
                             4'b0100, 4'b1000, 4'b0001, 4'b0000};
  logic       p4_yld [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       p4_vld [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] p5_rr  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                             4'b0010, 4'b0100, 4'b1000, 4'b0000};
  logic       p5_eng [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       p5_yld [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [3:0] e_rr;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.req_valid    = 4'b0000;
    bus.eng2sw_valid = 1'b0;
    bus.clq_full     = 1'b0;
    bus.flush        = 1'b0;
    set_cla(0);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.carb2sw_valid), 32'd0);
    check("rst_cla",   32'(bus.carb2sw), 32'd0);
    check("rst_src",   32'(bus.carb2sw_src), 32'd0);
    check("rst_yield", 32'(bus.yield), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    cyc();

    // Phase 1: all requesters valid, grants 0,1,2,3,0 back to back.
    set_cla(32'h1000);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(k % 4, 32'h1000 + (k % 4));
    for (int k = 0; k < 5; k++) begin
      #1;
      e_rr = 4'b0001 << (k % 4);
      check("p1_ready", 32'(bus.req_ready), 32'(e_rr));
      if (k > 0) check("p1_stream", 32'(bus.carb2sw_valid), 32'd1);
      cyc();
    end
    bus.req_valid = 4'b0000;
    cyc();
    cyc();

    // Phase 2: single requester, then wrap from pointer 3 to 0.
    set_cla(32'h2000);
    bus.req_valid = 4'b0100;
    push_exp(2, 32'h2002);
    #1;
    check("p2_ready2", 32'(bus.req_ready), 32'b0100);
    cyc();
    bus.req_valid = 4'b0000;
    #1;
    check("p2_ready_once", 32'(bus.req_ready), 32'd0);
    check("p2_src", 32'(bus.carb2sw_src), 32'd2);
    check("p2_valid", 32'(bus.carb2sw_valid), 32'd1);
    cyc();
    bus.req_valid = 4'b1001;
    push_exp(3, 32'h2003);
    push_exp(0, 32'h2000);
    #1;
    check("p2_ready3", 32'(bus.req_ready), 32'b1000);
    cyc();
    #1;
    check("p2_ready0", 32'(bus.req_ready), 32'b0001);
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    cyc();

    // Phase 3: clq_full stall holds the clause and blocks grants.
    set_cla(32'h3000);
    bus.req_valid = 4'b0010;
    push_exp(1, 32'h3001);
    #1;
    check("p3_ready1", 32'(bus.req_ready), 32'b0010);
    cyc();
    bus.clq_full  = 1'b1;
    bus.req_valid = 4'b1111;
    set_cla(32'h3100);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("p3_stall_valid", 32'(bus.carb2sw_valid), 32'd0);
      check("p3_stall_cla", 32'(bus.carb2sw), 32'h3001);
      check("p3_stall_src", 32'(bus.carb2sw_src), 32'd1);
      check("p3_stall_ready", 32'(bus.req_ready), 32'd0);
      cyc();
    end
    bus.clq_full  = 1'b0;
    bus.req_valid = 4'b0000;
    #1;
    check("p3_release_valid", 32'(bus.carb2sw_valid), 32'd1);
    check("p3_release_cla", 32'(bus.carb2sw), 32'h3001);
    cyc();
    cyc();

    // Phase 4: engine always waiting, yield after every 3 fires.
    set_cla(32'h4000);
    bus.eng2sw_valid = 1'b1;
    bus.req_valid    = 4'b1111;
    push_exp(2, 32'h4002); push_exp(3, 32'h4003); push_exp(0, 32'h4000);
    push_exp(1, 32'h4001); push_exp(2, 32'h4002); push_exp(3, 32'h4003);
    push_exp(0, 32'h4000);
    for (int k = 0; k < 9; k++) begin
      #1;
      check("p4_ready", 32'(bus.req_ready), 32'(p4_rr[k]));
      check("p4_yield", 32'(bus.yield), 32'(p4_yld[k]));
      check("p4_valid", 32'(bus.carb2sw_valid), 32'(p4_vld[k]));
      cyc();
    end
    bus.req_valid    = 4'b0000;
    bus.eng2sw_valid = 1'b0;
    cyc();
    cyc();

    // Phase 5: engine drops after 2 fires, so the yield is pushed out.
    set_cla(32'h5000);
    bus.req_valid = 4'b1111;
    push_exp(1, 32'h5001); push_exp(2, 32'h5002); push_exp(3, 32'h5003);
    push_exp(0, 32'h5000); push_exp(1, 32'h5001); push_exp(2, 32'h5002);
    push_exp(3, 32'h5003);
    for (int k = 0; k < 8; k++) begin
      bus.eng2sw_valid = p5_eng[k];
      #1;
      check("p5_ready", 32'(bus.req_ready), 32'(p5_rr[k]));
      check("p5_yield", 32'(bus.yield), 32'(p5_yld[k]));
      cyc();
    end
    bus.req_valid    = 4'b0000;
    bus.eng2sw_valid = 1'b0;
    cyc();
    cyc();

    // Phase 6: flush during a stall; pointer survives the flush.
    set_cla(32'h6000);
    bus.req_valid = 4'b0100;
    bus.clq_full  = 1'b1;
    #1;
    check("p6_ready2", 32'(bus.req_ready), 32'b0100);
    cyc();
    bus.req_valid = 4'b1111;
    bus.flush     = 1'b1;
    #1;
    check("p6_flush_ready", 32'(bus.req_ready), 32'd0);
    check("p6_flush_valid", 32'(bus.carb2sw_valid), 32'd0);
    cyc();
    bus.flush    = 1'b0;
    bus.clq_full = 1'b0;
    push_exp(3, 32'h6003);
    #1;
    check("p6_after_valid", 32'(bus.carb2sw_valid), 32'd0);
    check("p6_resume_ready", 32'(bus.req_ready), 32'b1000);
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    cyc();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
